// File: rtl/pipelined_cla_adder.sv
// Streaming add/subtract unit built from registered carry-look-ahead groups.
// One GROUP-bit slice resolves per stage; the carry moves between stages in flops.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic             CarryIN,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             CarryOUT,
  output logic             overflow
);

  localparam int NSTG = WIDTH / GROUP;

  if ((GROUP < 1) || (WIDTH % GROUP != 0)) begin : g_bad_param
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end

  typedef struct packed {
    logic             v;
    logic             sub;
    logic             c;
    logic             cm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stg_t;

  stg_t stg_q [NSTG];
  stg_t stg_d [NSTG];
  stg_t src   [NSTG];

  logic             advance;
  logic [GROUP-1:0] ag;
  logic [GROUP-1:0] bg;
  logic [GROUP-1:0] gg;
  logic [GROUP-1:0] pp;
  logic [GROUP:0]   cc;

  // Group carries as flat sum-of-products; no carry ripples inside the group.
  function automatic logic [GROUP:0] cla(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             ci
  );
    logic [GROUP:0] c;
    logic           acc;
    logic           t;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      acc = ci;
      for (int j = 0; j <= i; j++) acc = acc & p[j];
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        acc = acc | t;
      end
      c[i+1] = acc;
    end
    return c;
  endfunction

  // Stage inputs, per-stage group resolve, and global stall.
  always_comb begin
    advance = !stg_q[NSTG-1].v || out_ready;
    ag      = '0;
    bg      = '0;
    gg      = '0;
    pp      = '0;
    cc      = '0;

    // Bubbles enter with clean data so unknown inputs never travel.
    src[0]   = '0;
    src[0].v = in_valid;
    if (in_valid) begin
      src[0].sub = sub;
      src[0].c   = sub | CarryIN;
      src[0].a   = inp_a;
      src[0].b   = inp_b;
    end
    for (int k = 1; k < NSTG; k++) begin
      src[k] = stg_q[k-1];
    end

    for (int k = 0; k < NSTG; k++) begin
      stg_d[k] = stg_q[k];
      if (advance) begin
        ag = src[k].a[k*GROUP +: GROUP];
        bg = src[k].b[k*GROUP +: GROUP]
           ^ {GROUP{src[k].sub}};
        gg = ag & bg;
        pp = ag ^ bg;
        cc = cla(gg, pp, src[k].c);
        stg_d[k] = src[k];
        stg_d[k].s[k*GROUP +: GROUP] = pp ^ cc[GROUP-1:0];
        stg_d[k].c = cc[GROUP];
        if (k == NSTG - 1) begin
          stg_d[k].cm = cc[GROUP-1];
        end
      end
    end
  end

  // Pipeline registers; reset discards every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTG; k++) begin
        stg_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = stg_q[NSTG-1].v;
  assign SUM       = stg_q[NSTG-1].s;
  assign CarryOUT  = stg_q[NSTG-1].c;
  assign overflow  = stg_q[NSTG-1].c ^ stg_q[NSTG-1].cm;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed 16/4 checks plus
// randomised streams on 32/8 and 8/2 instances against a signed/unsigned model.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm,
                       input longint unsigned act,
                       input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, overflow from signed range.
  function automatic void ref_model(
    input  int              w,
    input  longint unsigned a,
    input  longint unsigned b,
    input  bit              ci,
    input  bit              s,
    output longint unsigned sm,
    output bit              co,
    output bit              ov
  );
    longint unsigned mask;
    longint unsigned tot;
    longint          sa, sb, r, lim;
    mask = (longint'(1) << w) - 1;
    lim  = longint'(1) << (w - 1);
    sa = (a >= lim) ? longint'(a) - longint'(mask) - 1 : longint'(a);
    sb = (b >= lim) ? longint'(b) - longint'(mask) - 1 : longint'(b);
    if (s) begin
      sm = (a - b) & mask;
      co = (a >= b);
      r  = sa - sb;
    end else begin
      tot = a + b + longint'(ci);
      sm  = tot & mask;
      co  = (tot >> w) != 0;
      r   = sa + sb + longint'(ci);
    end
    ov = (r >= lim) || (r < -lim);
  endfunction

  function automatic longint unsigned pick(input int w);
    longint unsigned mask;
    mask = (longint'(1) << w) - 1;
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return mask;
      2:       return longint'(1) << (w - 1);
      3:       return (longint'(1) << (w - 1)) - 1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  typedef struct {
    longint unsigned s;
    bit              co;
    bit              ov;
    int              cyc;
    bit              lat;
  } exp_t;

  // ---------------- directed instance, WIDTH=16 GROUP=4 ----------------
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] inp_a;
  logic [15:0] inp_b;
  logic        CarryIN;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] SUM;
  logic        CarryOUT;
  logic        overflow;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inp_a    (inp_a),
    .inp_b    (inp_b),
    .CarryIN  (CarryIN),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .SUM      (SUM),
    .CarryOUT (CarryOUT),
    .overflow (overflow)
  );

  exp_t q[$];
  exp_t pend;
  int   out_cycs[$];
  int   n_stall = 0;
  bit   held = 0;
  logic [15:0] h_sum;
  logic h_co, h_ov;

  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      exp_t e;
      e     = pend;
      e.cyc = cyc;
      q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      else check("in_ready_free", in_ready, 1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got SUM 0x%0h, want no beat", SUM);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sum", SUM, e.s);
          check("carry_out", CarryOUT, e.co);
          check("overflow", overflow, e.ov);
          if (e.lat) check("latency", longint'(cyc - e.cyc), 4);
          out_cycs.push_back(cyc);
        end
        held = 0;
      end else if (out_valid) begin
        n_stall++;
        if (held) begin
          check("stall_sum", SUM, h_sum);
          check("stall_co", CarryOUT, h_co);
          check("stall_ov", overflow, h_ov);
        end
        held  = 1;
        h_sum = SUM;
        h_co  = CarryOUT;
        h_ov  = overflow;
      end else begin
        held = 0;
      end
    end
  end

  task automatic issue();
    int n;
    bit acc;
    n   = 0;
    acc = 0;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    inp_a    = 'x;
    inp_b    = 'x;
    CarryIN  = 1'bx;
    sub      = 1'bx;
  endtask

  task automatic send_x(input logic [15:0] a, input logic [15:0] b,
                        input bit ci, input bit s,
                        input logic [15:0] es, input bit eco,
                        input bit eov, input bit lat);
    inp_a    = a;
    inp_b    = b;
    CarryIN  = ci;
    sub      = s;
    pend.s   = es;
    pend.co  = eco;
    pend.ov  = eov;
    pend.lat = lat;
    issue();
  endtask

  task automatic send_r(input bit lat);
    inp_a   = 16'($urandom);
    inp_b   = 16'($urandom);
    CarryIN = 1'($urandom);
    sub     = 1'($urandom);
    ref_model(16, inp_a, inp_b, CarryIN, sub, pend.s, pend.co, pend.ov);
    pend.lat = lat;
    issue();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(nm, q.size(), 0);
  endtask

  // ---------------- randomised instances ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : rnd
    localparam int W = (gi == 0) ? 32 : 8;
    localparam int G = (gi == 0) ? 8 : 2;

    logic         rr_n = 1'b0;
    logic         iv   = 1'b0;
    logic         ir;
    logic [W-1:0] a    = '0;
    logic [W-1:0] b    = '0;
    logic         ci   = 1'b0;
    logic         sb   = 1'b0;
    logic         ov_o;
    logic         ordy = 1'b1;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    exp_t         rq[$];
    exp_t         rpend;
    bit           done = 0;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) u (
      .clk      (clk),
      .rst_n    (rr_n),
      .in_valid (iv),
      .in_ready (ir),
      .inp_a    (a),
      .inp_b    (b),
      .CarryIN  (ci),
      .sub      (sb),
      .out_valid(ov_o),
      .out_ready(ordy),
      .SUM      (s),
      .CarryOUT (co),
      .overflow (ovf)
    );

    always @(negedge clk) begin
      if (rr_n && iv && ir) rq.push_back(rpend);
    end

    always @(negedge clk) begin
      if (rr_n && ov_o && ordy) begin
        if (rq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL r%0d_unexpected: got SUM 0x%0h, want no beat",
                   gi, s);
        end else begin
          exp_t e;
          e = rq.pop_front();
          check($sformatf("r%0d_sum", gi), s, e.s);
          check($sformatf("r%0d_co", gi), co, e.co);
          check($sformatf("r%0d_ov", gi), ovf, e.ov);
        end
      end
    end

    initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rr_n = 1'b1;
      for (int i = 0; i < 400; i++) begin
        @(posedge clk);
        #1;
        iv   = $urandom_range(0, 3) != 0;
        ordy = $urandom_range(0, 3) != 0;
        a    = W'(pick(W));
        b    = W'(pick(W));
        ci   = 1'($urandom);
        sb   = 1'($urandom);
        ref_model(W, a, b, ci, sb, rpend.s, rpend.co, rpend.ov);
      end
      @(posedge clk);
      #1;
      iv   = 1'b0;
      ordy = 1'b1;
      n = 0;
      while (rq.size() != 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
      #1;
      check($sformatf("r%0d_drain", gi), rq.size(), 0);
      done = 1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int st0;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    inp_a     = '0;
    inp_b     = '0;
    CarryIN   = 1'b0;
    sub       = 1'b0;
    pend      = '{default: 0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", SUM, 0);
    check("rst_carry_out", CarryOUT, 0);
    check("rst_overflow", overflow, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_x(16'h0002, 16'h0003, 0, 0, 16'h0005, 0, 0, 1);
    drain("t1_drain");

    send_x(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1);
    send_x(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 1);
    drain("t2_drain");

    send_x(16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 1);
    send_x(16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 1);
    send_x(16'h00FF, 16'h0000, 1, 0, 16'h0100, 0, 0, 1);
    send_x(16'h0009, 16'h0004, 0, 1, 16'h0005, 1, 0, 1);
    send_x(16'h0009, 16'h0004, 1, 1, 16'h0005, 1, 0, 1);
    drain("t3_drain");

    base = out_cycs.size();
    for (int i = 0; i < 8; i++) send_r(1);
    drain("t4_stream_drain");
    check("t4_stream_count", out_cycs.size() - base, 8);
    if (out_cycs.size() - base == 8) begin
      for (int i = 1; i < 8; i++) begin
        check("t4_consecutive",
              longint'(out_cycs[base+i] - out_cycs[base+i-1]), 1);
      end
    end

    st0  = n_stall;
    base = out_cycs.size();
    fork
      begin
        for (int i = 0; i < 8; i++) send_r(0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("t4_stall_drain");
    check("t4_stall_cycles", n_stall - st0, 3);
    check("t4_stall_count", out_cycs.size() - base, 8);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_r(0);
    @(posedge clk);
    #2;
    check("t5_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_sum", SUM, 0);
    check("t5_rst_in_ready", in_ready, 1);
    q.delete();
    held = 0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_x(16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0, 1);
    drain("t5_drain");

    n = 0;
    while (!(rnd[0].done && rnd[1].done) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("rnd_done", rnd[0].done && rnd[1].done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
